// File: rtl/calc1_pkg.sv
// calc1_pkg
//   Shared definitions for the calc1 port driver slice: calc1 command and
//   response encodings, the driver FSM state type and a command validity
//   helper used by the optional command pre-check.
//   No ports (package).
package calc1_pkg;

  // calc1 command encodings (4-bit, MSB-first)
  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  // calc1 response codes (2-bit, MSB-first); RSP_NONE means "no response this cycle"
  localparam logic [0:1] RSP_NONE = 2'd0;
  localparam logic [0:1] RSP_OK   = 2'd1;
  localparam logic [0:1] RSP_ERR  = 2'd2;
  localparam logic [0:1] RSP_IERR = 2'd3;

  // Driver FSM states, shared with anything that monitors the port protocol
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_OP1  = 3'd1,
    ST_SEND_OP2  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RESP_HOLD = 3'd4
  } drv_state_e;

  // True for the commands calc1 actually implements
  function automatic logic cmd_is_valid(input logic [0:3] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc1_wdog.sv
// calc1_wdog
//   Response watchdog for the calc1 port driver. Counts cycles spent waiting
//   for a calc1 response and flags expiry once TIMEOUT_CYCLES-1 is reached.
// Parameters
//   TIMEOUT_CYCLES  number of waiting cycles before expiry (>= 2)
// Ports
//   clk_i     in  clock, rising edge
//   rst_ni    in  asynchronous active-low reset (counter -> 0)
//   clear_i   in  clear counter to 0 (wins over enable_i)
//   enable_i  in  advance counter by one this cycle
//   expire_o  out counter has reached TIMEOUT_CYCLES-1
module calc1_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_o = (cnt_q == LAST);

  // Counter parks at LAST so expire_o stays asserted until the next clear
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc1_port_driver.sv
// calc1_port_driver
//   Upstream request driver for one calc1 port. Accepts one op over a
//   valid/ready request channel, issues it to calc1 with the two-cycle
//   request protocol (cmd+op1, then op2), waits for the one-cycle calc1
//   response (or a watchdog timeout) and holds the result on a valid/ready
//   response channel. Only one op is outstanding at a time.
// Configuration
//   CALC1_DRV_CMD_CHECK_EN  when defined, unsupported commands are accepted
//                           but never issued; they complete at once with
//                           status RSP_ERR. Default: forward every command.
// Parameters
//   TIMEOUT_CYCLES  waiting cycles before a timeout result (>= 2)
// Ports
//   c_clk, reset_n                     clock / async active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_cmd, req_op1, req_op2          op to issue
//   rsp_valid/rsp_ready                response handshake
//   rsp_status, rsp_data, rsp_timeout  result (status 0 only on timeout)
//   calc_cmd_out, calc_data_out        registered request lines to calc1
//   calc_resp_in, calc_data_in         response lines from calc1
//   stray_cnt                          saturating count of unexpected responses
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_op1,
  input  logic [0:31] req_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_status,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic [0:3]  calc_cmd_out,
  output logic [0:31] calc_data_out,
  input  logic [0:1]  calc_resp_in,
  input  logic [0:31] calc_data_in,
  output logic [0:7]  stray_cnt
);

  drv_state_e  state_q, state_d;
  logic [0:3]  cmd_q, cmd_d;
  logic [0:31] cdata_q, cdata_d;
  logic [0:31] op2_q, op2_d;
  logic [0:1]  status_q, status_d;
  logic [0:31] rdata_q, rdata_d;
  logic        tmo_q, tmo_d;
  logic [0:7]  stray_q, stray_d;

  logic wdog_clr;
  logic wdog_en;
  logic wdog_expire;
  logic resp_seen;

  assign resp_seen = (calc_resp_in != RSP_NONE);

  calc1_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (c_clk),
    .rst_ni   (reset_n),
    .clear_i  (wdog_clr),
    .enable_i (wdog_en),
    .expire_o (wdog_expire)
  );

  // Next-state and datapath logic. A response arriving on the last watchdog
  // edge is checked first so it wins over the timeout.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cdata_d  = cdata_q;
    op2_d    = op2_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    stray_d  = stray_q;
    wdog_clr = 1'b0;
    wdog_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef CALC1_DRV_CMD_CHECK_EN
          if (!cmd_is_valid(req_cmd)) begin
            status_d = RSP_ERR;
            rdata_d  = '0;
            tmo_d    = 1'b0;
            state_d  = ST_RESP_HOLD;
          end else begin
            cmd_d   = req_cmd;
            cdata_d = req_op1;
            op2_d   = req_op2;
            state_d = ST_SEND_OP1;
          end
`else
          cmd_d   = req_cmd;
          cdata_d = req_op1;
          op2_d   = req_op2;
          state_d = ST_SEND_OP1;
`endif
        end
      end
      ST_SEND_OP1: begin
        cmd_d   = CMD_NOP;
        cdata_d = op2_q;
        state_d = ST_SEND_OP2;
      end
      ST_SEND_OP2: begin
        cdata_d  = '0;
        wdog_clr = 1'b1;
        state_d  = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (resp_seen) begin
          status_d = calc_resp_in;
          rdata_d  = calc_data_in;
          tmo_d    = 1'b0;
          state_d  = ST_RESP_HOLD;
        end else if (wdog_expire) begin
          status_d = RSP_NONE;
          rdata_d  = '0;
          tmo_d    = 1'b1;
          state_d  = ST_RESP_HOLD;
        end else begin
          wdog_en = 1'b1;
        end
      end
      ST_RESP_HOLD: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Responses outside WAIT_RESP are only counted, never captured
    if (resp_seen && (state_q != ST_WAIT_RESP) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      cdata_q  <= '0;
      op2_q    <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      tmo_q    <= 1'b0;
      stray_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cdata_q  <= cdata_d;
      op2_q    <= op2_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      stray_q  <= stray_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP_HOLD);
  assign rsp_status    = status_q;
  assign rsp_data      = rdata_q;
  assign rsp_timeout   = tmo_q;
  assign calc_cmd_out  = cmd_q;
  assign calc_data_out = cdata_q;
  assign stray_cnt     = stray_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// tb_calc1_port_driver
//   Directed bench for calc1_port_driver with a small behavioural calc1
//   model on the request/response lines. Table vectors cover the normal
//   op flow; hand-written sequences cover the protocol timing, timeout,
//   stray responses, back-pressure and mid-op reset.
module tb_calc1_port_driver;
  import calc1_pkg::*;

  localparam int TMO = 8;

  logic        c_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [0:3]  req_cmd = '0;
  logic [0:31] req_op1 = '0;
  logic [0:31] req_op2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [0:1]  rsp_status;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic [0:3]  calc_cmd_out;
  logic [0:31] calc_data_out;
  logic [0:1]  calc_resp_in;
  logic [0:31] calc_data_in;
  logic [0:7]  stray_cnt;

  // calc1 model outputs and manual injection, OR-ed onto the response lines
  logic [0:1]  modelResp = '0;
  logic [0:31] modelData = '0;
  logic [0:1]  injResp = '0;
  logic [0:31] injData = '0;
  logic        modelEn = 1'b1;
  int          modelDelay = 1;

  assign calc_resp_in = modelResp | injResp;
  assign calc_data_in = modelData | injData;

  int checks = 0;
  int errors = 0;

  always #5 c_clk = ~c_clk;

  calc1_port_driver #(.TIMEOUT_CYCLES(TMO)) dut (
    .c_clk         (c_clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_status    (rsp_status),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout),
    .calc_cmd_out  (calc_cmd_out),
    .calc_data_out (calc_data_out),
    .calc_resp_in  (calc_resp_in),
    .calc_data_in  (calc_data_in),
    .stray_cnt     (stray_cnt)
  );

  // Behavioural calc1: sees cmd+op1, then op2, answers modelDelay cycles later
  initial begin : calc1Model
    int          mdlWait;
    logic [0:3]  mCmd;
    logic [0:31] mOp1;
    logic [0:31] mOp2;
    logic [0:1]  mStatus;
    logic [0:31] mResult;
    logic [32:0] sum;
    mdlWait = 0;
    mStatus = '0;
    mResult = '0;
    forever begin
      @(negedge c_clk);
      modelResp = '0;
      modelData = '0;
      if (mdlWait > 0) begin
        mdlWait--;
        if (mdlWait == 0 && modelEn) begin
          modelResp = mStatus;
          modelData = mResult;
        end
      end else if (reset_n && calc_cmd_out != CMD_NOP) begin
        mCmd = calc_cmd_out;
        mOp1 = calc_data_out;
        @(negedge c_clk);
        mOp2 = calc_data_out;
        mStatus = RSP_ERR;
        mResult = '0;
        case (mCmd)
          CMD_ADD: begin
            sum = {1'b0, mOp1} + {1'b0, mOp2};
            if (!sum[32]) begin
              mStatus = RSP_OK;
              mResult = sum[31:0];
            end
          end
          CMD_SUB: begin
            if (mOp2 <= mOp1) begin
              mStatus = RSP_OK;
              mResult = mOp1 - mOp2;
            end
          end
          CMD_SHL: begin
            mStatus = RSP_OK;
            mResult = mOp1 << mOp2[27:31];
          end
          CMD_SHR: begin
            mStatus = RSP_OK;
            mResult = mOp1 >> mOp2[27:31];
          end
          default: ;
        endcase
        mdlWait = modelDelay;
      end
    end
  end

  typedef struct {
    string       name;
    logic [0:3]  cmd;
    logic [0:31] op1;
    logic [0:31] op2;
    int          delay;
    logic [0:1]  expStatus;
    logic [0:31] expData;
    logic        expTmo;
    int          expLat;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Presents one op; returns at the falling edge right after the accept edge
  task automatic applyStimulus(input logic [0:3] cmd, input logic [0:31] a, input logic [0:31] b);
    @(negedge c_clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_op1   = a;
    req_op2   = b;
    @(negedge c_clk);
    req_valid = 1'b0;
    req_cmd   = '0;
    req_op1   = '0;
    req_op2   = '0;
  endtask

  // Counts edges after the accept edge until rsp_valid shows, bounded
  task automatic waitResp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 60) begin
      @(negedge c_clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_valid_wait actual=0 expected=1 after %0d cycles", lat);
    end
  endtask

  task automatic releaseResp();
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
  endtask

  initial begin : mainTest
    int lat;
    logic [0:1]  holdStatus;
    logic [0:31] holdData;

    vecs[0] = '{"add_basic",   CMD_ADD, 32'h0000_0001, 32'h01FF_FFFF, 1, RSP_OK,  32'h0200_0000, 1'b0, 3};
    vecs[1] = '{"add_ovf",     CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2, RSP_ERR, 32'h0000_0000, 1'b0, 4};
    vecs[2] = '{"sub_unf",     CMD_SUB, 32'h0000_0001, 32'h0000_000F, 3, RSP_ERR, 32'h0000_0000, 1'b0, 5};
    vecs[3] = '{"shl_31",      CMD_SHL, 32'h0000_0001, 32'h0000_001F, 1, RSP_OK,  32'h8000_0000, 1'b0, 3};
    vecs[4] = '{"shr_1",       CMD_SHR, 32'h8000_0000, 32'h0000_0001, 4, RSP_OK,  32'h4000_0000, 1'b0, 6};
    vecs[5] = '{"sub_ok",      CMD_SUB, 32'h0000_0010, 32'h0000_0003, 1, RSP_OK,  32'h0000_000D, 1'b0, 3};
    vecs[6] = '{"resp_at_tmo", CMD_ADD, 32'h0000_0002, 32'h0000_0003, TMO, RSP_OK, 32'h0000_0005, 1'b0, 2 + TMO};

    // Reset state
    #2 reset_n = 1'b0;
    @(negedge c_clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("rst_calc_cmd", 32'(calc_cmd_out), 32'd0);
    checkOutput("rst_calc_data", calc_data_out, 32'd0);
    checkOutput("rst_stray", 32'(stray_cnt), 32'd0);
    @(negedge c_clk);
    reset_n = 1'b1;

    // Table-driven ops
    for (int i = 0; i < 7; i++) begin
      modelDelay = vecs[i].delay;
      applyStimulus(vecs[i].cmd, vecs[i].op1, vecs[i].op2);
      waitResp(0, lat);
      checkOutput($sformatf("%s_status", vecs[i].name), 32'(rsp_status), 32'(vecs[i].expStatus));
      checkOutput($sformatf("%s_data", vecs[i].name), rsp_data, vecs[i].expData);
      checkOutput($sformatf("%s_tmo", vecs[i].name), 32'(rsp_timeout), 32'(vecs[i].expTmo));
      checkOutput($sformatf("%s_lat", vecs[i].name), 32'(lat), 32'(vecs[i].expLat));
      releaseResp();
    end
    checkOutput("stray_after_table", 32'(stray_cnt), 32'd0);

    // Request sequence on calc1 lines, cycle-exact
    $display("[TB] request line sequence");
    modelDelay = 3;
    applyStimulus(CMD_SHL, 32'h0000_0001, 32'h0000_001F);
    checkOutput("seq0_cmd", 32'(calc_cmd_out), 32'd5);
    checkOutput("seq0_data", calc_data_out, 32'h1);
    @(negedge c_clk);
    checkOutput("seq1_cmd", 32'(calc_cmd_out), 32'd0);
    checkOutput("seq1_data", calc_data_out, 32'h1F);
    @(negedge c_clk);
    checkOutput("seq2_cmd", 32'(calc_cmd_out), 32'd0);
    checkOutput("seq2_data", calc_data_out, 32'h0);
    waitResp(2, lat);
    checkOutput("seq_lat", 32'(lat), 32'd5);
    checkOutput("seq_data", rsp_data, 32'h8000_0000);
    releaseResp();

    // Unsupported command 3
    $display("[TB] unsupported command");
    modelDelay = 1;
    applyStimulus(4'd3, 32'h0000_0004, 32'h0000_0005);
`ifdef CALC1_DRV_CMD_CHECK_EN
    checkOutput("cmd3_not_issued", 32'(calc_cmd_out), 32'd0);
    waitResp(0, lat);
    checkOutput("cmd3_lat", 32'(lat), 32'd0);
    checkOutput("cmd3_cmd_still0", 32'(calc_cmd_out), 32'd0);
`else
    checkOutput("cmd3_issued", 32'(calc_cmd_out), 32'd3);
    waitResp(0, lat);
    checkOutput("cmd3_lat", 32'(lat), 32'd3);
`endif
    checkOutput("cmd3_status", 32'(rsp_status), 32'd2);
    checkOutput("cmd3_data", rsp_data, 32'd0);
    checkOutput("cmd3_tmo", 32'(rsp_timeout), 32'd0);
    releaseResp();

    // Silent calc1 -> timeout, then a stray response while holding
    $display("[TB] timeout and stray");
    modelEn = 1'b0;
    applyStimulus(CMD_ADD, 32'h1, 32'h1);
    waitResp(0, lat);
    checkOutput("tmo_lat", 32'(lat), 32'(2 + TMO));
    checkOutput("tmo_flag", 32'(rsp_timeout), 32'd1);
    checkOutput("tmo_status", 32'(rsp_status), 32'd0);
    checkOutput("tmo_data", rsp_data, 32'd0);
    injResp = RSP_OK;
    injData = 32'h1234_5678;
    @(negedge c_clk);
    injResp = '0;
    injData = '0;
    checkOutput("stray_one", 32'(stray_cnt), 32'd1);
    checkOutput("stray_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("stray_rsp_tmo", 32'(rsp_timeout), 32'd1);
    checkOutput("stray_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("stray_rsp_data", rsp_data, 32'd0);
    releaseResp();
    modelEn = 1'b1;

    // Back-pressure: result held while rsp_ready is low
    $display("[TB] response hold");
    modelDelay = 2;
    applyStimulus(CMD_ADD, 32'h0000_0100, 32'h0000_0200);
    waitResp(0, lat);
    holdStatus = rsp_status;
    holdData   = rsp_data;
    checkOutput("hold_data_val", rsp_data, 32'h0000_0300);
    for (int c = 0; c < 10; c++) begin
      @(negedge c_clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_status", 32'(rsp_status), 32'(holdStatus));
      checkOutput("hold_data", rsp_data, holdData);
    end
    releaseResp();
    checkOutput("post_hold_req_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of WAIT_RESP
    $display("[TB] reset during wait");
    modelEn = 1'b0;
    modelDelay = 1;
    applyStimulus(CMD_ADD, 32'h9, 32'h9);
    repeat (4) @(negedge c_clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("mid_rst_rsp_data", rsp_data, 32'd0);
    checkOutput("mid_rst_calc_cmd", 32'(calc_cmd_out), 32'd0);
    checkOutput("mid_rst_stray", 32'(stray_cnt), 32'd0);
    @(negedge c_clk);
    reset_n = 1'b1;
    modelEn = 1'b1;
    applyStimulus(CMD_ADD, 32'h0000_0007, 32'h0000_0008);
    waitResp(0, lat);
    checkOutput("after_rst_lat", 32'(lat), 32'd3);
    checkOutput("after_rst_status", 32'(rsp_status), 32'd1);
    checkOutput("after_rst_data", rsp_data, 32'h0000_000F);
    releaseResp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
